// File: rtl/gsu_register_pkg.sv
// Shared types and constants for the GSU general-register bank.
// Optional build macro used by gsu_register_file: GSU_REGISTER_WRITE_BYPASS_EN.
package gsu_register_pkg;

  localparam int REGISTER_COUNT = 16;

  typedef logic [3:0] reg_index_t;

  localparam reg_index_t PC_INDEX          = 4'd15;
  localparam reg_index_t ROM_ADDRESS_INDEX = 4'd14;

  // Operand word slots on the packed 64-bit operand bus
  localparam int SREG_WORD = 0;
  localparam int RN_WORD   = 1;
  localparam int DREG_WORD = 2;
  localparam int PC_WORD   = 3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PREFIXED = 1'b1
  } prefix_state_t;

endpackage

// File: rtl/gsu_prefix_state.sv
// FROM/TO/WITH prefix tracking: holds Sreg, Dreg and the B flag.
//
//   state       | meaning
//   ST_IDLE     | Sreg = Dreg = 0, B = 0
//   ST_PREFIXED | some prefix selection or B flag is live
module gsu_prefix_state
  import gsu_register_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  reg_index_t rn_select,
  input  logic       prefix_from,
  input  logic       prefix_to,
  input  logic       prefix_with,
  input  logic       instruction_done,
  output reg_index_t sreg_index,
  output reg_index_t dreg_index,
  output logic       b_flag
);

  prefix_state_t state_q, state_d;
  reg_index_t    sreg_q, sreg_d;
  reg_index_t    dreg_q, dreg_d;
  logic          b_q, b_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      dreg_q  <= '0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dreg_q  <= dreg_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    sreg_d  = sreg_q;
    dreg_d  = dreg_q;
    b_d     = b_q;
    state_d = state_q;
    // Clear first so a prefix arriving with instruction_done lands on a clean state
    if (instruction_done || state_q == ST_IDLE) begin
      sreg_d = '0;
      dreg_d = '0;
      b_d    = 1'b0;
    end
    if (prefix_with) begin
      sreg_d = rn_select;
      dreg_d = rn_select;
      b_d    = 1'b1;
    end else if (prefix_to) begin
      dreg_d = rn_select;
    end else if (prefix_from) begin
      sreg_d = rn_select;
    end
    state_d = (sreg_d != '0 || dreg_d != '0 || b_d) ? ST_PREFIXED : ST_IDLE;
  end

  assign sreg_index = sreg_q;
  assign dreg_index = dreg_q;
  assign b_flag     = b_q;

endmodule

// File: rtl/gsu_register_file.sv
// GSU general registers R0-R15 with prefix selection, PC increment and R14 fetch pulse.
// Define GSU_REGISTER_WRITE_BYPASS_EN to forward same-cycle writes onto operand_bus.
module gsu_register_file
  import gsu_register_pkg::*;
#(
  parameter int                        REGISTER_WIDTH = 16,
  parameter logic [REGISTER_WIDTH-1:0] RESET_VALUE    = 16'h0000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  reg_index_t                  rn_select,
  input  logic                        prefix_from,
  input  logic                        prefix_to,
  input  logic                        prefix_with,
  input  logic                        instruction_done,
  input  logic                        dreg_write_enable,
  input  logic                        rn_write_enable,
  input  logic [REGISTER_WIDTH-1:0]   write_data,
  input  logic                        pc_increment,
  output logic [4*REGISTER_WIDTH-1:0] operand_bus,
  output reg_index_t                  sreg_index,
  output reg_index_t                  dreg_index,
  output logic                        b_flag,
  output logic                        rom_fetch_request
);

  logic [REGISTER_WIDTH-1:0] regs_q     [REGISTER_COUNT];
  logic [REGISTER_WIDTH-1:0] next_value [REGISTER_COUNT];
  logic [REGISTER_WIDTH-1:0] words      [4];
  logic [REGISTER_COUNT-1:0] write_hit;
  logic                      fetch_q;

  gsu_prefix_state u_prefix_state (
    .clock            (clock),
    .reset            (reset),
    .rn_select        (rn_select),
    .prefix_from      (prefix_from),
    .prefix_to        (prefix_to),
    .prefix_with      (prefix_with),
    .instruction_done (instruction_done),
    .sreg_index       (sreg_index),
    .dreg_index       (dreg_index),
    .b_flag           (b_flag)
  );

  // Both write ports carry the same write_data, so an Rn/Dreg collision
  // resolves to the same value; dreg_index here is the pre-update Dreg.
  always_comb begin
    for (int i = 0; i < REGISTER_COUNT; i++) begin
      write_hit[i]  = (rn_write_enable   && rn_select  == reg_index_t'(i)) ||
                      (dreg_write_enable && dreg_index == reg_index_t'(i));
      next_value[i] = write_hit[i] ? write_data : regs_q[i];
    end
    if (pc_increment && !write_hit[PC_INDEX])
      next_value[PC_INDEX] = regs_q[PC_INDEX] + REGISTER_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGISTER_COUNT; i++) regs_q[i] <= RESET_VALUE;
      fetch_q <= 1'b0;
    end else begin
      for (int i = 0; i < REGISTER_COUNT; i++) regs_q[i] <= next_value[i];
      fetch_q <= write_hit[ROM_ADDRESS_INDEX];
    end
  end

  always_comb begin
`ifdef GSU_REGISTER_WRITE_BYPASS_EN
    words[SREG_WORD] = write_hit[sreg_index] ? write_data : regs_q[sreg_index];
    words[RN_WORD]   = write_hit[rn_select]  ? write_data : regs_q[rn_select];
    words[DREG_WORD] = write_hit[dreg_index] ? write_data : regs_q[dreg_index];
    words[PC_WORD]   = next_value[PC_INDEX];
`else
    words[SREG_WORD] = regs_q[sreg_index];
    words[RN_WORD]   = regs_q[rn_select];
    words[DREG_WORD] = regs_q[dreg_index];
    words[PC_WORD]   = regs_q[PC_INDEX];
`endif
    for (int k = 0; k < 4; k++)
      operand_bus[k*REGISTER_WIDTH +: REGISTER_WIDTH] = words[k];
  end

  assign rom_fetch_request = fetch_q;

endmodule

// File: tb/tb_gsu_register_file.sv
// Self-checking bench for gsu_register_file: vector table, corner sequences, random vs model.
module tb_gsu_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  rn_select;
  logic        prefix_from, prefix_to, prefix_with, instruction_done;
  logic        dreg_write_enable, rn_write_enable, pc_increment;
  logic [15:0] write_data;
  logic [63:0] operand_bus;
  logic [3:0]  sreg_index, dreg_index;
  logic        b_flag, rom_fetch_request;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_reg [16];
  logic [3:0]  m_s, m_d;
  logic        m_b, m_f;

  gsu_register_file dut (
    .clock             (clock),
    .reset             (reset),
    .rn_select         (rn_select),
    .prefix_from       (prefix_from),
    .prefix_to         (prefix_to),
    .prefix_with       (prefix_with),
    .instruction_done  (instruction_done),
    .dreg_write_enable (dreg_write_enable),
    .rn_write_enable   (rn_write_enable),
    .write_data        (write_data),
    .pc_increment      (pc_increment),
    .operand_bus       (operand_bus),
    .sreg_index        (sreg_index),
    .dreg_index        (dreg_index),
    .b_flag            (b_flag),
    .rom_fetch_request (rom_fetch_request)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  rn;
    logic        p_from, p_to, p_with, done, dwe, rwe, inc;
    logic [15:0] data;
    logic [3:0]  e_s, e_d;
    logic        e_b, e_f;
    logic [15:0] e_w2;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; prefix_from = 0; prefix_to = 0; prefix_with = 0; instruction_done = 0;
    dreg_write_enable = 0; rn_write_enable = 0; pc_increment = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".bus"},   operand_bus, {m_reg[15], m_reg[m_d], m_reg[rn_select], m_reg[m_s]});
    check({tag, ".sreg"},  64'(sreg_index), 64'(m_s));
    check({tag, ".dreg"},  64'(dreg_index), 64'(m_d));
    check({tag, ".b"},     64'(b_flag), 64'(m_b));
    check({tag, ".fetch"}, 64'(rom_fetch_request), 64'(m_f));
  endtask

  // Advance one clock: model computes the spec's next state from the applied
  // inputs, then enables drop so the post-edge read shows registered contents.
  task automatic cycle(input string tag);
    logic [15:0] nreg [16];
    logic [3:0]  ns, nd;
    logic        nb, nf, w15;
    nreg = m_reg;
    if (reset) begin
      for (int i = 0; i < 16; i++) nreg[i] = 16'h0000;
      ns = 0; nd = 0; nb = 0; nf = 0;
    end else begin
      if (dreg_write_enable) nreg[m_d] = write_data;
      if (rn_write_enable)   nreg[rn_select] = write_data;
      nf  = (dreg_write_enable && m_d == 14) || (rn_write_enable && rn_select == 14);
      w15 = (dreg_write_enable && m_d == 15) || (rn_write_enable && rn_select == 15);
      if (pc_increment && !w15) nreg[15] = m_reg[15] + 16'd1;
      ns = instruction_done ? 4'd0 : m_s;
      nd = instruction_done ? 4'd0 : m_d;
      nb = instruction_done ? 1'b0 : m_b;
      if (prefix_with) begin ns = rn_select; nd = rn_select; nb = 1; end
      else if (prefix_to) nd = rn_select;
      else if (prefix_from) ns = rn_select;
    end
    @(posedge clock);
    m_reg = nreg; m_s = ns; m_d = nd; m_b = nb; m_f = nf;
    #1 idle_inputs();
    #1 check_model(tag);
  endtask

  vec_t vecs [14];

  initial begin
    for (int i = 0; i < 16; i++) m_reg[i] = 16'hxxxx;
    m_s = 'x; m_d = 'x; m_b = 'x; m_f = 'x;
    idle_inputs();
    rn_select = 0; write_data = 0;

    // reset
    reset = 1; cycle("reset0");
    reset = 1; cycle("reset1");
    check("reset.bus", operand_bus, 64'h0);
    check("reset.b", 64'(b_flag), 64'h0);

    //            rn  frm to wth dne dwe rwe inc data      s  d  b  f  w2
    vecs[0]  = '{4'd3, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 3, 3, 1, 0, 16'h0000};
    vecs[1]  = '{4'd0, 0, 0, 0, 0, 1, 0, 0, 16'hBEEF, 3, 3, 1, 0, 16'hBEEF};
    vecs[2]  = '{4'd0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000};
    vecs[3]  = '{4'd5, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 5, 0, 0, 0, 16'h0000};
    vecs[4]  = '{4'd7, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 5, 7, 0, 0, 16'h0000};
    vecs[5]  = '{4'd0, 0, 0, 0, 0, 1, 0, 0, 16'h1234, 5, 7, 0, 0, 16'h1234};
    vecs[6]  = '{4'd0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000};
    vecs[7]  = '{4'd9, 1, 1, 1, 0, 0, 0, 0, 16'h0000, 9, 9, 1, 0, 16'h0000};
    vecs[8]  = '{4'd4, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 0, 4, 0, 0, 16'h0000};
    vecs[9]  = '{4'd2, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 2, 0, 0, 16'h0000};
    vecs[10] = '{4'd14,0, 0, 0, 0, 1, 1, 0, 16'h5555, 0, 2, 0, 1, 16'h5555};
    vecs[11] = '{4'd2, 0, 0, 0, 0, 1, 1, 0, 16'h7777, 0, 2, 0, 0, 16'h7777};
    vecs[12] = '{4'd0, 0, 0, 0, 1, 1, 0, 0, 16'h4321, 0, 0, 0, 0, 16'h0000};
    vecs[13] = '{4'd2, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 2, 0, 0, 16'h4321};

    for (int i = 0; i < 14; i++) begin
      rn_select = vecs[i].rn; prefix_from = vecs[i].p_from; prefix_to = vecs[i].p_to;
      prefix_with = vecs[i].p_with; instruction_done = vecs[i].done;
      dreg_write_enable = vecs[i].dwe; rn_write_enable = vecs[i].rwe;
      pc_increment = vecs[i].inc; write_data = vecs[i].data;
      cycle("vec");
      check($sformatf("vec%0d.sreg", i), 64'(sreg_index), 64'(vecs[i].e_s));
      check($sformatf("vec%0d.dreg", i), 64'(dreg_index), 64'(vecs[i].e_d));
      check($sformatf("vec%0d.b", i), 64'(b_flag), 64'(vecs[i].e_b));
      check($sformatf("vec%0d.fetch", i), 64'(rom_fetch_request), 64'(vecs[i].e_f));
      check($sformatf("vec%0d.word2", i), 64'(operand_bus[47:32]), 64'(vecs[i].e_w2));
    end

    // R15 wrap and write-over-increment
    rn_select = 15; rn_write_enable = 1; write_data = 16'hFFFF; cycle("pc_load");
    check("pc_load.word3", 64'(operand_bus[63:48]), 64'hFFFF);
    pc_increment = 1; cycle("pc_wrap");
    check("pc_wrap.word3", 64'(operand_bus[63:48]), 64'h0000);
    pc_increment = 1; rn_select = 15; rn_write_enable = 1; write_data = 16'h0100; cycle("pc_wr");
    check("pc_write_wins.word3", 64'(operand_bus[63:48]), 64'h0100);

    // R14 back-to-back fetch pulses; reset with a pending write cancels the pulse
    rn_select = 14; rn_write_enable = 1; write_data = 16'h8000; cycle("r14a");
    check("r14.pulse1", 64'(rom_fetch_request), 64'h1);
    rn_select = 14; rn_write_enable = 1; write_data = 16'h8000; cycle("r14b");
    check("r14.pulse2", 64'(rom_fetch_request), 64'h1);
    reset = 1; rn_select = 14; rn_write_enable = 1; write_data = 16'h8000; cycle("r14rst");
    check("r14.reset_cancel", 64'(rom_fetch_request), 64'h0);
    check("r14.reset_bus", operand_bus, 64'h0);
    cycle("r14idle");
    check("r14.idle", 64'(rom_fetch_request), 64'h0);

    // same-cycle read of a register being written
    rn_select = 2; rn_write_enable = 1; write_data = 16'hA5A5;
    #1;
`ifdef GSU_REGISTER_WRITE_BYPASS_EN
    check("bypass.same_cycle", 64'(operand_bus[31:16]), 64'hA5A5);
`else
    check("nobypass.same_cycle", 64'(operand_bus[31:16]), 64'h0000);
`endif
    cycle("raw");
    check("raw.next_cycle", 64'(operand_bus[31:16]), 64'hA5A5);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rn_select = 4'($urandom_range(0, 15));
      if ($urandom % 4 == 0) rn_select = 4'(14 + ($urandom % 2));
      prefix_from       = ($urandom % 4) == 0;
      prefix_to         = ($urandom % 4) == 0;
      prefix_with       = ($urandom % 6) == 0;
      instruction_done  = ($urandom % 3) == 0;
      dreg_write_enable = ($urandom % 2) == 0;
      rn_write_enable   = ($urandom % 3) == 0;
      pc_increment      = ($urandom % 2) == 0;
      write_data        = 16'($urandom);
      if ($urandom % 8 == 0) write_data = 16'hFFFF;
      reset             = ($urandom % 60) == 0;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
